// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: program-memory read port, branch redirect input and
// the valid/ready instruction channel towards execute.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr_hi;
  logic [15:0]       out_instr_lo;
  logic [2:0]        out_group;
  logic [ADDR_W-1:0] out_pc;
  logic [15:0]       issued_count;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr_hi, out_instr_lo, out_group, out_pc, issued_count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr_hi, out_instr_lo, out_group, out_pc, issued_count
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch controller: reads one or two 16-bit words per instruction,
// classifies the opcode group and hands the result to execute via valid/ready.
module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam logic [1:0] S_REQ_HI = 2'd0;
  localparam logic [1:0] S_REQ_LO = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       instr_hi_q, instr_hi_d;
  logic [15:0]       instr_lo_q, instr_lo_d;
  logic [2:0]        group_q, group_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [15:0]       issued_count_q, issued_count_d;

  function automatic logic [2:0] classify(input logic [15:0] w);
    if (!w[15])                     return 3'd1;
    else if (w[15:14] == 2'b10)     return 3'd2;
    else if (w[15:12] == 4'b1100)   return 3'd3;
    else if (w[15:12] == 4'b1101)   return 3'd4;
    else if (w[15:10] == 6'b111000) return 3'd5;
    else                            return 3'd0;
  endfunction

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_hi_d     = instr_hi_q;
    instr_lo_d     = instr_lo_q;
    group_d        = group_q;
    out_pc_d       = out_pc_q;
    issued_count_d = issued_count_q;

    // Read data acked alongside a redirect belongs to the abandoned path.
    case (state_q)
      S_REQ_HI: begin
        if (bus.mem_ack && !bus.redirect_valid) begin
          instr_hi_d = bus.mem_rdata;
          instr_lo_d = 16'h0000;
          group_d    = classify(bus.mem_rdata);
          out_pc_d   = pc_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = (classify(bus.mem_rdata) == 3'd5) ? S_REQ_LO : S_ISSUE;
        end
      end
      S_REQ_LO: begin
        if (bus.mem_ack && !bus.redirect_valid) begin
          instr_lo_d = bus.mem_rdata;
          pc_d       = pc_q + PC_STEP;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_valid_q && bus.out_ready) begin
          issued_count_d = issued_count_q + 16'd1;
          state_d        = S_REQ_HI;
        end
      end
      default: state_d = S_REQ_HI;
    endcase

    // A handshake in the redirect cycle still counts; only the PC/state move.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = S_REQ_HI;
    end

    out_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_REQ_HI;
      pc_q           <= RESET_PC;
      out_valid_q    <= 1'b0;
      instr_hi_q     <= 16'h0000;
      instr_lo_q     <= 16'h0000;
      group_q        <= 3'd0;
      out_pc_q       <= '0;
      issued_count_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      instr_hi_q     <= instr_hi_d;
      instr_lo_q     <= instr_lo_d;
      group_q        <= group_d;
      out_pc_q       <= out_pc_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign bus.mem_req      = (state_q == S_REQ_HI) || (state_q == S_REQ_LO);
  assign bus.mem_addr     = pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr_hi = instr_hi_q;
  assign bus.out_instr_lo = instr_lo_q;
  assign bus.out_group    = group_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.issued_count = issued_count_q;

endmodule
